// File: rtl/mem_sb_pkg.sv
// Shared types and default widths for the store-buffered memory stage
// (mem_stage_sb and its sb_fifo).
package mem_sb_pkg;

    localparam int unsigned SB_ADDR_W_DEF = 16;
    localparam int unsigned SB_DATA_W_DEF = 16;
    localparam int unsigned SB_DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic [SB_ADDR_W_DEF-1:0] addr;
        logic [SB_DATA_W_DEF-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: circular storage, pointers, count and a youngest-match
// address search. The hit_data port exists only when MEM_SB_FWD_EN is defined.
module sb_fifo
    import mem_sb_pkg::*;
#(
    parameter int unsigned ADDR_W   = SB_ADDR_W_DEF,
    parameter int unsigned DATA_W   = SB_DATA_W_DEF,
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic              hit
`ifdef MEM_SB_FWD_EN
    ,
    output logic [DATA_W-1:0] hit_data
`endif
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q [SB_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= '{addr: push_addr, data: push_data};
    end

    assign head_addr = mem_q[head_q].addr;
    assign head_data = mem_q[head_q].data;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(SB_DEPTH));

    // Walk oldest to youngest so the last (youngest) match wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef MEM_SB_FWD_EN
        hit_data = '0;
`endif
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_q[idx].addr == lookup_addr)) begin
                hit = 1'b1;
`ifdef MEM_SB_FWD_EN
                hit_data = mem_q[idx].data;
`endif
            end
        end
    end

endmodule

// File: rtl/mem_stage_sb.sv
// Memory stage with an N-entry store buffer draining to mem_system in the
// background. Define MEM_SB_FWD_EN to forward buffered store data to loads.
module mem_stage_sb
    import mem_sb_pkg::*;
#(
    parameter int unsigned ADDR_W   = SB_ADDR_W_DEF,
    parameter int unsigned DATA_W   = SB_DATA_W_DEF,
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] XOut,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              createdump,
    output logic [DATA_W-1:0] MemOut,
    output logic              DC_Stall,
    output logic              err,
    output logic [ADDR_W-1:0] c_Addr,
    output logic [DATA_W-1:0] c_DataIn,
    output logic              c_Rd,
    output logic              c_Wr,
    output logic              c_createdump,
    input  logic [DATA_W-1:0] c_DataOut,
    input  logic              c_Done,
    input  logic              c_err
);

    sb_state_e         state_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              full, empty, hit;
    logic              misuse, misalign, x_err;
    logic              ld_ok, st_ok, fwd;
    logic              push, pop, issue_rd, issue_wr, ld_done, dump_ok;
`ifdef MEM_SB_FWD_EN
    logic [DATA_W-1:0] fwd_data;
`endif

    assign misuse   = MemRead & MemWrite;
    assign misalign = XOut[0] & (MemRead | MemWrite);
    assign ld_ok    = MemRead & ~MemWrite & ~XOut[0];
    assign st_ok    = MemWrite & ~MemRead & ~XOut[0];

    // Unknown-value detection only exists in simulation builds.
`ifndef SYNTHESIS
    assign x_err = $isunknown({MemRead, MemWrite, createdump})
                 || ((MemRead | MemWrite) && $isunknown(XOut))
                 || (MemWrite && $isunknown(WriteData));
`else
    assign x_err = 1'b0;
`endif

`ifdef MEM_SB_FWD_EN
    assign fwd = ld_ok & hit;
`else
    assign fwd = 1'b0;
`endif

    assign push     = st_ok & ~full;
    assign pop      = (state_q == DRAIN) & c_Done;
    assign issue_rd = (state_q == IDLE) & ld_ok & ~hit;
    assign issue_wr = (state_q == IDLE) & ~issue_rd & ~empty;
    assign ld_done  = (state_q == LOAD) & c_Done;
    assign dump_ok  = (state_q == IDLE) & empty;

    sb_fifo #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SB_DEPTH (SB_DEPTH)
    ) u_sb_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (XOut),
        .push_data   (WriteData),
        .pop         (pop),
        .lookup_addr (XOut),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (full),
        .empty       (empty),
        .hit         (hit)
`ifdef MEM_SB_FWD_EN
        ,
        .hit_data    (fwd_data)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ld_addr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (issue_rd) begin
                        state_q   <= LOAD;
                        ld_addr_q <= XOut;
                    end else if (issue_wr) begin
                        state_q <= DRAIN;
                    end
                end
                LOAD:    if (c_Done) state_q <= IDLE;
                DRAIN:   if (c_Done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held so nothing reaches the cache.
    always_comb begin
        MemOut       = '0;
        DC_Stall     = 1'b0;
        err          = 1'b0;
        c_Addr       = '0;
        c_DataIn     = '0;
        c_Rd         = 1'b0;
        c_Wr         = 1'b0;
        c_createdump = 1'b0;
        if (rst_n) begin
            err = misalign | misuse | x_err | c_err;
            if (issue_rd) begin
                c_Rd   = 1'b1;
                c_Addr = XOut;
            end else if (issue_wr) begin
                c_Wr     = 1'b1;
                c_Addr   = head_addr;
                c_DataIn = head_data;
            end else if (state_q == LOAD) begin
                c_Addr = ld_addr_q;
            end else if (state_q == DRAIN) begin
                c_Addr   = head_addr;
                c_DataIn = head_data;
            end
`ifdef MEM_SB_FWD_EN
            if (fwd) MemOut = fwd_data;
            else
`endif
            if (ld_done) MemOut = c_DataOut;
            DC_Stall = (st_ok & full)
                     | (ld_ok & ~fwd & ~ld_done)
                     | (createdump & ~dump_ok);
            c_createdump = createdump & dump_ok;
        end
    end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb with a fixed-latency cache model.
// Expectations follow MEM_SB_FWD_EN when the bench is built with it.
module tb_mem_stage_sb;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] XOut;
    logic [DW-1:0] WriteData;
    logic          MemWrite, MemRead, createdump;
    logic [DW-1:0] MemOut;
    logic          DC_Stall, err;
    logic [AW-1:0] c_Addr;
    logic [DW-1:0] c_DataIn;
    logic          c_Rd, c_Wr, c_createdump;
    logic [DW-1:0] c_DataOut;
    logic          c_Done;
    logic          c_err;

    int unsigned   n_total = 0;
    int unsigned   n_bad = 0;

    logic [DW-1:0] cmem [0:255];
    logic [AW-1:0] wr_log [$];
    logic [AW-1:0] rd_addr;
    logic          is_rd;
    int unsigned   pend;
    int unsigned   n_done;
    int unsigned   n_rd;

    always #5 clk = ~clk;

    mem_stage_sb #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SB_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .XOut         (XOut),
        .WriteData    (WriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .createdump   (createdump),
        .MemOut       (MemOut),
        .DC_Stall     (DC_Stall),
        .err          (err),
        .c_Addr       (c_Addr),
        .c_DataIn     (c_DataIn),
        .c_Rd         (c_Rd),
        .c_Wr         (c_Wr),
        .c_createdump (c_createdump),
        .c_DataOut    (c_DataOut),
        .c_Done       (c_Done),
        .c_err        (c_err)
    );

    // Cache: accepts a request mid-cycle, answers with c_Done LAT cycles later.
    initial begin
        for (int i = 0; i < 256; i++) cmem[i] = '0;
        cmem[8'h20] = 16'hA5A5;
        c_Done = 1'b0; c_DataOut = '0; pend = 0; n_done = 0; n_rd = 0;
        is_rd = 1'b0; rd_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (c_Done) n_done++;
                if (c_Wr) begin
                    wr_log.push_back(c_Addr);
                    cmem[c_Addr[8:1]] = c_DataIn;
                    is_rd = 1'b0;
                    pend = LAT;
                end
                if (c_Rd) begin
                    rd_addr = c_Addr;
                    is_rd = 1'b1;
                    n_rd++;
                    pend = LAT;
                end
            end
            @(posedge clk);
            #1;
            c_Done = 1'b0;
            c_DataOut = '0;
            if (!rst_n) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    c_Done = 1'b1;
                    c_DataOut = is_rd ? cmem[rd_addr[8:1]] : 16'hDEAD;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic dump,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        MemRead = rd; MemWrite = wr; createdump = dump; XOut = a; WriteData = d;
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drained(input string tag, input int unsigned nwr);
        int unsigned k = 0;
        sample();
        while (!(wr_log.size() == nwr && pend == 0 && !c_Done) && k < 300) begin
            k++;
            sample();
        end
        check(tag, 32'(k < 300), 32'd1);
    endtask

    initial begin
        int unsigned stalls, k, d0, r0, n0, bad_cd, wr_seen;
        logic prev_done, rd_after_done, rd_addr_ok;

        c_err = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0100, '0);
        #3;
        check("rst_stall", 32'(DC_Stall), 0);
        check("rst_c_rd", 32'(c_Rd), 0);
        check("rst_memout", 32'(MemOut), 0);
        check("rst_err", 32'(err), 0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #19;
        rst_n = 1'b1;

        // Five back-to-back stores into a 4-deep buffer
        for (int i = 0; i < 5; i++) begin
            at_edge();
            drive(1'b0, 1'b1, 1'b0, 16'(16'h0010 + 2 * i), 16'(16'h1000 + i));
            sample();
            if (i == 1) begin
                check("st_first_cwr", 32'(c_Wr), 1);
                check("st_first_caddr", 32'(c_Addr), 32'h0010);
            end
            stalls = 0;
            while (DC_Stall && stalls < 50) begin
                stalls++;
                sample();
            end
            check($sformatf("st%0d_stalls", i), stalls, (i == 4) ? 2 : 0);
        end
        at_edge();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        wait_drained("st_drain_done", 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("st_order%0d", i), 32'(wr_log[i]), 32'(16'h0010 + 2 * i));
        check("st_data_last", 32'(cmem[8'h0C]), 32'h1004);

        // Two stores to one address, then a load of it
        at_edge(); drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'hBEEF);
        sample();  check("fw_st1_stall", 32'(DC_Stall), 0);
        at_edge(); drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234);
        sample();  check("fw_st2_memout", 32'(MemOut), 0);
        at_edge(); drive(1'b1, 1'b0, 1'b0, 16'h0020, '0);
        sample();
`ifdef MEM_SB_FWD_EN
        check("fw_memout", 32'(MemOut), 32'h1234);
        check("fw_stall", 32'(DC_Stall), 0);
        check("fw_no_crd", 32'(c_Rd), 0);
`else
        r0 = n_rd; k = 0;
        check("nf_stall", 32'(DC_Stall), 1);
        while (DC_Stall && k < 100) begin
            k++;
            sample();
        end
        check("nf_timeout", 32'(k < 100), 1);
        check("nf_memout", 32'(MemOut), 32'h1234);
        check("nf_one_read", n_rd - r0, 1);
        check("nf_rd_addr", 32'(rd_addr), 32'h0020);
        check("nf_drained_first", wr_log.size(), 7);
`endif
        at_edge(); drive(1'b0, 1'b0, 1'b0, '0, '0);
        wait_drained("fw_drain_done", 7);

        // Buffer-miss load while a drain is in flight
        at_edge(); drive(1'b0, 1'b1, 1'b0, 16'h0030, 16'h3333);
        sample();
        at_edge(); drive(1'b0, 1'b1, 1'b0, 16'h0032, 16'h3232);
        sample();
        at_edge(); drive(1'b1, 1'b0, 1'b0, 16'h0040, '0);
        sample();
        check("ld_drain_stall", 32'(DC_Stall), 1);
        r0 = n_rd; k = 0; rd_after_done = 1'b0; rd_addr_ok = 1'b0;
        while (DC_Stall && k < 100) begin
            prev_done = c_Done;
            sample();
            k++;
            if (c_Rd) begin
                rd_after_done = prev_done;
                rd_addr_ok = (c_Addr == 16'h0040);
            end
        end
        check("ld_timeout", 32'(k < 100), 1);
        check("ld_memout", 32'(MemOut), 32'hA5A5);
        check("ld_one_read", n_rd - r0, 1);
        check("ld_rd_after_done", 32'(rd_after_done), 1);
        check("ld_rd_addr", 32'(rd_addr_ok), 1);
        check("ld_one_drain", wr_log.size(), 8);
        at_edge(); drive(1'b0, 1'b0, 1'b0, '0, '0);
        wait_drained("ld_drain_resume", 9);
        check("ld_last_wr", 32'(wr_log[8]), 32'h0032);

        // Error cases
        at_edge(); drive(1'b1, 1'b0, 1'b0, 16'h0043, '0);
        sample();
        check("mis_ld_err", 32'(err), 1);
        check("mis_ld_stall", 32'(DC_Stall), 0);
        check("mis_ld_crd", 32'(c_Rd), 0);
        at_edge(); drive(1'b0, 1'b1, 1'b0, 16'h0045, 16'h5555);
        sample();
        check("mis_st_err", 32'(err), 1);
        check("mis_st_stall", 32'(DC_Stall), 0);
        at_edge(); drive(1'b1, 1'b1, 1'b0, 16'h0044, 16'h4444);
        sample();
        check("both_err", 32'(err), 1);
        check("both_stall", 32'(DC_Stall), 0);
        check("both_crd", 32'(c_Rd), 0);
        at_edge(); drive(1'b0, 1'b0, 1'b0, '0, '0); c_err = 1'b1;
        sample();
        check("cerr_err", 32'(err), 1);
        check("cerr_no_cwr", 32'(c_Wr), 0);
        at_edge(); c_err = 1'b0;
        sample();
        check("cerr_clear", 32'(err), 0);
        check("err_no_enqueue", wr_log.size(), 9);

        // createdump with two entries queued
        at_edge(); drive(1'b0, 1'b1, 1'b0, 16'h0050, 16'h5050);
        sample();
        at_edge(); drive(1'b0, 1'b1, 1'b0, 16'h0052, 16'h5252);
        sample();
        at_edge(); drive(1'b0, 1'b0, 1'b1, '0, '0);
        sample();
        check("dump_stall", 32'(DC_Stall), 1);
        d0 = n_done; k = 0; bad_cd = 0;
        while (DC_Stall && k < 100) begin
            if (c_createdump) bad_cd++;
            sample();
            k++;
        end
        check("dump_timeout", 32'(k < 100), 1);
        check("dump_pulse", 32'(c_createdump), 1);
        check("dump_two_done", n_done - d0, 2);
        check("dump_early", bad_cd, 0);
        check("dump_drained", wr_log.size(), 11);
        at_edge(); drive(1'b0, 1'b0, 1'b0, '0, '0);
        sample();
        check("dump_release", 32'(c_createdump), 0);

        // Reset asserted mid-drain with three entries queued
        for (int i = 0; i < 3; i++) begin
            at_edge(); drive(1'b0, 1'b1, 1'b0, 16'(16'h0060 + 2 * i), 16'(16'h6000 + i));
            sample();
            check($sformatf("rs_st%0d_stall", i), 32'(DC_Stall), 0);
        end
        at_edge(); drive(1'b1, 1'b0, 1'b0, 16'h0070, '0);
        sample();
        check("rs_pre_stall", 32'(DC_Stall), 1);
        n0 = wr_log.size();
        rst_n = 1'b0;
        #1;
        check("rs_stall", 32'(DC_Stall), 0);
        check("rs_cwr", 32'(c_Wr), 0);
        check("rs_crd", 32'(c_Rd), 0);
        check("rs_memout", 32'(MemOut), 0);
        at_edge(); drive(1'b0, 1'b0, 1'b0, '0, '0);
        sample();
        rst_n = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (c_Wr) wr_seen++;
        end
        check("rs_no_cwr", wr_seen, 0);
        check("rs_no_drain", wr_log.size(), n0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
